// File: rtl/fwp_wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
// Optional watchdog is enabled by FWP_WB_ARB_TIMEOUT_EN.
package fwp_wb_arb_pkg;

    localparam int MAX_INIT = 8;
    localparam int IDX_W    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Zero-padded request bits above N_INIT are never picked, so a fixed
    // modulo-8 walk gives the same answer as a modulo-N_INIT walk.
    function automatic logic [MAX_INIT-1:0] rr_pick(
        input logic [MAX_INIT-1:0] req,
        input logic [IDX_W-1:0]    last
    );
        logic [MAX_INIT-1:0] gnt;
        logic [IDX_W-1:0]    idx;
        gnt = '0;
        for (int i = 1; i <= MAX_INIT; i++) begin
            idx = last + IDX_W'(i);
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwp_rr_pick.sv
// Combinational round-robin selector: request vector plus last winner
// index in, one-hot next winner out.
module fwp_rr_pick
    import fwp_wb_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [N-1:0]     next_gnt
);

    logic [MAX_INIT-1:0] req_pad;

    always_comb begin
        req_pad        = '0;
        req_pad[N-1:0] = req;
        next_gnt       = N'(rr_pick(req_pad, last_gnt));
    end

endmodule

// File: rtl/fwp_wb_arbiter.sv
// Round-robin classic Wishbone arbiter in front of the user wrapper port.
// Define FWP_WB_ARB_TIMEOUT_EN to add the stalled-target watchdog.
module fwp_wb_arbiter
    import fwp_wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int N_INIT         = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_INIT*ADDR_WIDTH-1:0]   i_adr,
    input  logic [N_INIT*DATA_WIDTH-1:0]   i_dat_w,
    input  logic [N_INIT*DATA_WIDTH/8-1:0] i_sel,
    input  logic [N_INIT-1:0]              i_cyc,
    input  logic [N_INIT-1:0]              i_stb,
    input  logic [N_INIT-1:0]              i_we,
    output logic [DATA_WIDTH-1:0]          i_dat_r,
    output logic [N_INIT-1:0]              i_ack,
    output logic [N_INIT-1:0]              i_err,
    output logic [ADDR_WIDTH-1:0]          t_adr,
    output logic [DATA_WIDTH-1:0]          t_dat_w,
    output logic [DATA_WIDTH/8-1:0]        t_sel,
    output logic                           t_cyc,
    output logic                           t_stb,
    output logic                           t_we,
    input  logic [DATA_WIDTH-1:0]          t_dat_r,
    input  logic                           t_ack,
    input  logic                           t_err,
    output logic [N_INIT-1:0]              gnt_o
`ifdef FWP_WB_ARB_TIMEOUT_EN
    ,
    output logic                           timeout_o
`endif
);

    localparam int SW = DATA_WIDTH / 8;

    if (N_INIT < 2 || N_INIT > MAX_INIT || DATA_WIDTH % 8 != 0
        || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("fwp_wb_arbiter: illegal parameter");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] last_gnt;
    logic [N_INIT-1:0] next_gnt;
    logic [IDX_W-1:0] next_idx;
    logic             stb_sel;
    logic             expire;

    fwp_rr_pick #(.N(N_INIT)) u_pick (
        .req      (i_cyc),
        .last_gnt (last_gnt),
        .next_gnt (next_gnt)
    );

    always_comb begin
        next_idx = '0;
        for (int k = 0; k < N_INIT; k++) begin
            if (next_gnt[k]) next_idx = IDX_W'(k);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            gnt_o    <= '0;
            last_gnt <= IDX_W'(N_INIT - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (|i_cyc) begin
                        state    <= GRANT;
                        gnt_o    <= next_gnt;
                        last_gnt <= next_idx;
                    end
                end
                GRANT: begin
                    if (!(|(i_cyc & gnt_o))) begin
                        state <= IDLE;
                        gnt_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // AND-OR mux on the one-hot grant; all zero outside GRANT
    always_comb begin
        t_adr   = '0;
        t_dat_w = '0;
        t_sel   = '0;
        t_cyc   = 1'b0;
        stb_sel = 1'b0;
        t_we    = 1'b0;
        if (state == GRANT) begin
            for (int k = 0; k < N_INIT; k++) begin
                if (gnt_o[k]) begin
                    t_adr   = i_adr[k*ADDR_WIDTH +: ADDR_WIDTH];
                    t_dat_w = i_dat_w[k*DATA_WIDTH +: DATA_WIDTH];
                    t_sel   = i_sel[k*SW +: SW];
                    t_cyc   = i_cyc[k];
                    stb_sel = i_stb[k];
                    t_we    = i_we[k];
                end
            end
        end
    end

    assign t_stb   = stb_sel & ~expire;
    assign i_dat_r = t_dat_r;
    assign i_ack   = gnt_o & {N_INIT{t_ack}};
    assign i_err   = gnt_o & {N_INIT{t_err | expire}};

`ifdef FWP_WB_ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt;
    logic          stalled;

    assign stalled = (state == GRANT) && t_cyc && stb_sel && !(t_ack || t_err);
    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle
    assign expire  = stalled && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (!stalled || expire) wd_cnt <= '0;
            else                    wd_cnt <= wd_cnt + 1'b1;
            if (expire) timeout_o <= 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_fwp_wb_arbiter.sv
// Directed self-checking bench for fwp_wb_arbiter (N_INIT=2).
// Watchdog vectors run only when FWP_WB_ARB_TIMEOUT_EN is defined.
module tb_fwp_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 2;
    localparam int SW = DW / 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [N*AW-1:0] i_adr;
    logic [N*DW-1:0] i_dat_w;
    logic [N*SW-1:0] i_sel;
    logic [N-1:0]    i_cyc;
    logic [N-1:0]    i_stb;
    logic [N-1:0]    i_we;
    logic [DW-1:0]   i_dat_r;
    logic [N-1:0]    i_ack;
    logic [N-1:0]    i_err;
    logic [AW-1:0]   t_adr;
    logic [DW-1:0]   t_dat_w;
    logic [SW-1:0]   t_sel;
    logic            t_cyc;
    logic            t_stb;
    logic            t_we;
    logic [DW-1:0]   t_dat_r;
    logic            t_ack;
    logic            t_err;
    logic [N-1:0]    gnt_o;
`ifdef FWP_WB_ARB_TIMEOUT_EN
    logic            timeout_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fwp_wb_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .N_INIT         (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .i_adr   (i_adr),
        .i_dat_w (i_dat_w),
        .i_sel   (i_sel),
        .i_cyc   (i_cyc),
        .i_stb   (i_stb),
        .i_we    (i_we),
        .i_dat_r (i_dat_r),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .t_adr   (t_adr),
        .t_dat_w (t_dat_w),
        .t_sel   (t_sel),
        .t_cyc   (t_cyc),
        .t_stb   (t_stb),
        .t_we    (t_we),
        .t_dat_r (t_dat_r),
        .t_ack   (t_ack),
        .t_err   (t_err),
        .gnt_o   (gnt_o)
`ifdef FWP_WB_ARB_TIMEOUT_EN
        ,
        .timeout_o (timeout_o)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int k, input logic cyc, input logic stb,
                         input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        i_cyc[k]             = cyc;
        i_stb[k]             = stb;
        i_we[k]              = we;
        i_adr[k*AW +: AW]    = adr;
        i_dat_w[k*DW +: DW]  = dat;
        i_sel[k*SW +: SW]    = sel;
    endtask

    initial begin
        int o;
        reset   = 1'b1;
        i_adr   = '0;
        i_dat_w = '0;
        i_sel   = '0;
        i_cyc   = '0;
        i_stb   = '0;
        i_we    = '0;
        t_dat_r = '0;
        t_ack   = 1'b0;
        t_err   = 1'b0;

        step();
        chk("rst_t_cyc", t_cyc, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_t_adr", t_adr, 0);
        step();
        reset = 1'b0;

        // single write from initiator 0
        drive(0, 1, 1, 1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        settle();
        chk("wr_lat_t_cyc", t_cyc, 0);
        step();
        chk("wr_t_cyc", t_cyc, 1);
        chk("wr_t_stb", t_stb, 1);
        chk("wr_t_we", t_we, 1);
        chk("wr_t_adr", t_adr, 64'h3000_0004);
        chk("wr_t_dat_w", t_dat_w, 64'hDEAD_BEEF);
        chk("wr_t_sel", t_sel, 4'hF);
        chk("wr_gnt", gnt_o, 2'b01);
        chk("wr_ack_pre", i_ack, 0);
        t_ack = 1'b1;
        settle();
        chk("wr_ack", i_ack, 2'b01);
        step();
        drive(0, 0, 0, 0, '0, '0, '0);
        t_ack = 1'b0;
        settle();
        chk("wr_rel_t_cyc", t_cyc, 0);
        chk("wr_rel_ack", i_ack, 0);
        step();
        chk("wr_idle_gnt", gnt_o, 0);

        // contention: both request, re-request right after release
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(0, 1, 1, 0, 32'h0000_0100, '0, 4'hF);
        drive(1, 1, 1, 0, 32'h0000_0200, '0, 4'hF);
        step();
        for (int t = 0; t < 4; t++) begin
            o = t % 2;
            chk($sformatf("rr%0d_gnt", t), gnt_o, 64'(1 << o));
            chk($sformatf("rr%0d_adr", t), t_adr, 64'(32'h100 * (o + 1)));
            t_dat_r = 32'hA0 + 32'(t);
            t_ack   = 1'b1;
            settle();
            chk($sformatf("rr%0d_ack", t), i_ack, 64'(1 << o));
            chk($sformatf("rr%0d_dat_r", t), i_dat_r, 64'(32'hA0 + t));
            step();
            i_cyc[o] = 1'b0;
            t_ack    = 1'b0;
            settle();
            chk($sformatf("rr%0d_rel_cyc", t), t_cyc, 0);
            step();
            chk($sformatf("rr%0d_idle_gnt", t), gnt_o, 0);
            i_cyc[o] = 1'b1;
            settle();
            chk($sformatf("rr%0d_idle_cyc", t), t_cyc, 0);
            step();
        end
        i_cyc = '0;
        step();

        // lock: initiator 1 holds cyc over 3 reads while 0 requests
        drive(1, 1, 0, 0, 32'h0000_0300, '0, 4'hF);
        step();
        i_cyc[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            i_stb[1] = 1'b1;
            t_dat_r  = 32'hB0 + 32'(j);
            t_ack    = 1'b1;
            settle();
            chk($sformatf("lk%0d_gnt", j), gnt_o, 2'b10);
            chk($sformatf("lk%0d_ack", j), i_ack, 2'b10);
            chk($sformatf("lk%0d_dat_r", j), i_dat_r, 64'(32'hB0 + j));
            chk($sformatf("lk%0d_adr", j), t_adr, 64'h300);
            step();
            i_stb[1] = 1'b0;
            t_ack    = 1'b0;
            settle();
            chk($sformatf("lk%0d_gap_gnt", j), gnt_o, 2'b10);
            chk($sformatf("lk%0d_gap_stb", j), t_stb, 0);
            chk($sformatf("lk%0d_gap_cyc", j), t_cyc, 1);
            step();
        end
        i_cyc[1] = 1'b0;
        settle();
        chk("lk_rel_cyc", t_cyc, 0);
        step();
        chk("lk_idle_gnt", gnt_o, 0);
        step();
        chk("lk_next_gnt", gnt_o, 2'b01);
        chk("lk_next_adr", t_adr, 64'h100);

        // reset while initiator 0 waits for ack
        i_cyc[1] = 1'b1;
        reset    = 1'b1;
        step();
        t_ack = 1'b1;
        settle();
        chk("rs_t_cyc", t_cyc, 0);
        chk("rs_gnt", gnt_o, 0);
        chk("rs_ack", i_ack, 0);
        reset = 1'b0;
        t_ack = 1'b0;
        step();
        chk("rs_first_gnt", gnt_o, 2'b01);

        // error pass-through on initiator 1 write
        i_cyc = '0;
        step();
        drive(1, 1, 1, 1, 32'h0000_0400, 32'h55AA_55AA, 4'h3);
        step();
        t_err = 1'b1;
        settle();
        chk("er_gnt", gnt_o, 2'b10);
        chk("er_err", i_err, 2'b10);
        chk("er_ack", i_ack, 0);
        chk("er_sel", t_sel, 4'h3);
        step();
        t_err = 1'b0;
        settle();
        chk("er_err_clr", i_err, 0);
        i_cyc = '0;
        step();
        step();

`ifdef FWP_WB_ARB_TIMEOUT_EN
        // target never answers: watchdog fires on 16th stalled cycle
        drive(0, 1, 1, 0, 32'h0000_0500, '0, 4'hF);
        step();
        chk("to_gnt", gnt_o, 2'b01);
        chk("to_flag_pre", timeout_o, 0);
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("to_wait%0d", k), i_err, 0);
            step();
        end
        chk("to_err", i_err, 2'b01);
        chk("to_stb_kill", t_stb, 0);
        step();
        chk("to_flag", timeout_o, 1);
        chk("to_err_clr", i_err, 0);
        i_cyc = '0;
        step();
        chk("to_flag_hold", timeout_o, 1);
        reset = 1'b1;
        step();
        chk("to_flag_rst", timeout_o, 0);
        reset = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
